// File: rtl/counter_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : counter_step_scheduler
// Purpose  : Round-robin scheduler sharing one up/down step counter among
//            NREQ burst requesters; bursts stop at 0 / 2^WIDTH-1 (no wrap).
// Options  : COUNTER_SCHED_ASSERT_EN embeds concurrent SVA checks.
// Revision : 1.0  initial release
// ============================================================================
module counter_step_scheduler #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int LENW  = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      dir,
  input  logic [NREQ*LENW-1:0] len,
  input  logic                 clr,
  input  logic [WIDTH-1:0]     cnt,
  output logic                 ctr_reset,
  output logic                 up,
  output logic                 down,
  output logic [NREQ-1:0]      gnt,
  output logic                 busy,
  output logic                 done,
  output logic                 sat,
  output logic                 aborted
);

  localparam int                c_PTRW     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [c_PTRW-1:0] c_PTR_LAST = c_PTRW'(NREQ - 1);
  localparam logic [LENW-1:0]   c_REM_ONE  = LENW'(1);
  localparam logic [0:0]        c_IDLE     = 1'b0;
  localparam logic [0:0]        c_RUN      = 1'b1;

  logic [0:0]        r_state;
  logic              r_cur_dir;
  logic [LENW-1:0]   r_remaining;
  logic [c_PTRW-1:0] r_rr_ptr;
  logic [NREQ-1:0]   r_gnt;
  logic              r_done;
  logic              r_sat;
  logic              r_aborted;
  logic              r_ctr_reset;

  logic [0:0]        w_state_nxt;
  logic              w_cur_dir_nxt;
  logic [LENW-1:0]   w_remaining_nxt;
  logic [c_PTRW-1:0] w_rr_ptr_nxt;
  logic [NREQ-1:0]   w_gnt_nxt;
  logic              w_done_nxt;
  logic              w_sat_nxt;
  logic              w_aborted_nxt;
  logic              w_ctr_reset_nxt;

  logic              w_any_req;
  logic [c_PTRW-1:0] w_sel;
  logic              w_up;
  logic              w_down;
  logic              w_busy;

  // Circular priority search: lowest offset from r_rr_ptr wins, so the loop
  // runs from the far end and lets nearer requesters overwrite the choice.
  always_comb begin
    int idx;
    idx       = 0;
    w_any_req = 1'b0;
    w_sel     = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(r_rr_ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (req[idx]) begin
        w_any_req = 1'b1;
        w_sel     = c_PTRW'(idx);
      end
    end
  end

  // State register and registered pulse outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= c_IDLE;
      r_cur_dir   <= 1'b0;
      r_remaining <= '0;
      r_rr_ptr    <= '0;
      r_gnt       <= '0;
      r_done      <= 1'b0;
      r_sat       <= 1'b0;
      r_aborted   <= 1'b0;
      r_ctr_reset <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cur_dir   <= w_cur_dir_nxt;
      r_remaining <= w_remaining_nxt;
      r_rr_ptr    <= w_rr_ptr_nxt;
      r_gnt       <= w_gnt_nxt;
      r_done      <= w_done_nxt;
      r_sat       <= w_sat_nxt;
      r_aborted   <= w_aborted_nxt;
      r_ctr_reset <= w_ctr_reset_nxt;
    end
  end

  // Next-state logic. The edge that issues the final step already returns to
  // IDLE so done lands one cycle after the last step.
  always_comb begin
    w_state_nxt     = r_state;
    w_cur_dir_nxt   = r_cur_dir;
    w_remaining_nxt = r_remaining;
    w_rr_ptr_nxt    = r_rr_ptr;
    w_gnt_nxt       = '0;
    w_done_nxt      = 1'b0;
    w_sat_nxt       = 1'b0;
    w_aborted_nxt   = 1'b0;
    w_ctr_reset_nxt = 1'b0;
    if (clr) begin
      w_state_nxt     = c_IDLE;
      w_remaining_nxt = '0;
      w_ctr_reset_nxt = 1'b1;
      if (r_state == c_RUN) begin
        w_done_nxt    = 1'b1;
        w_aborted_nxt = 1'b1;
      end
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_any_req) begin
            w_state_nxt      = c_RUN;
            w_cur_dir_nxt    = dir[w_sel];
            w_remaining_nxt  = len[int'(w_sel)*LENW +: LENW];
            w_rr_ptr_nxt     = (w_sel == c_PTR_LAST) ? '0 : w_sel + 1'b1;
            w_gnt_nxt[w_sel] = 1'b1;
          end
        end
        c_RUN: begin
          if (r_remaining == '0) begin
            w_state_nxt = c_IDLE;
            w_done_nxt  = 1'b1;
          end else if (!w_up && !w_down) begin
            // Steps still owed but the counter sits at the limit in our direction
            w_state_nxt     = c_IDLE;
            w_remaining_nxt = '0;
            w_done_nxt      = 1'b1;
            w_sat_nxt       = 1'b1;
          end else begin
            w_remaining_nxt = r_remaining - 1'b1;
            if (r_remaining == c_REM_ONE) begin
              w_state_nxt = c_IDLE;
              w_done_nxt  = 1'b1;
            end
          end
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  // Combinational outputs
  always_comb begin
    w_busy = (r_state == c_RUN);
    w_up   = w_busy &  r_cur_dir & (r_remaining != '0) & (cnt != '1);
    w_down = w_busy & ~r_cur_dir & (r_remaining != '0) & (cnt != '0);
  end

  assign up        = w_up;
  assign down      = w_down;
  assign busy      = w_busy;
  assign gnt       = r_gnt;
  assign done      = r_done;
  assign sat       = r_sat;
  assign aborted   = r_aborted;
  assign ctr_reset = r_ctr_reset;

`ifdef COUNTER_SCHED_ASSERT_EN
  default clocking cb_sva @(posedge clk); endclocking
  default disable iff (!reset_n);

  a_up_down_excl : assert property (!(up && down));
  a_gnt_onehot   : assert property ($onehot0(gnt));
  a_gnt_busy     : assert property (|gnt |-> busy);
  a_up_limit     : assert property (up |-> cnt != '1);
  a_down_limit   : assert property (down |-> cnt != '0);
  a_zero_done    : assert property (busy && !clr && r_remaining == '0 |=> done);

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_req_stable
    m_req_hold : assume property ($fell(req[gi]) |-> gnt[gi] || $past(gnt[gi]));
  end
`else
`endif

endmodule
`default_nettype wire

// File: tb/tb_counter_step_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_counter_step_scheduler
// Purpose  : Directed + random bench for counter_step_scheduler with an
//            attached step counter and a burst-level reference model.
// Revision : 1.0  initial release
// ============================================================================
module tb_counter_step_scheduler;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int LENW  = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic                 clk = 1'b0;
  logic                 reset_n;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      dir;
  logic [NREQ*LENW-1:0] len;
  logic                 clr;
  logic [WIDTH-1:0]     cnt;
  logic                 ctr_reset, up, down, busy, done, sat, aborted;
  logic [NREQ-1:0]      gnt;
  logic                 ld;
  logic [WIDTH-1:0]     ld_val;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  counter_step_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .LENW(LENW)) u_dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req       (req),
    .dir       (dir),
    .len       (len),
    .clr       (clr),
    .cnt       (cnt),
    .ctr_reset (ctr_reset),
    .up        (up),
    .down      (down),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .sat       (sat),
    .aborted   (aborted)
  );

  // The shared step counter, with a bench-only preload
  always @(posedge clk) begin
    if (ld)             cnt <= ld_val;
    else if (ctr_reset) cnt <= '0;
    else if (up)        cnt <= cnt + 1'b1;
    else if (down)      cnt <= cnt - 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      if (n_errors <= 40) $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: each granted burst is planned as a whole at grant time
  // (step count clipped by headroom, end cycle), then outputs follow the plan.
  int       cyc = 0;
  bit       m_active = 1'b0;
  int       m_k = 0, m_n = 0, m_done_c = 0, m_ptr = 0, m_cnt = 0;
  bit       m_dir = 1'b0, m_sat = 1'b0, m_busy_c = 1'b0;
  int       m_idx = 0, m_len = 0, m_head = 0;
  bit       e_up = 0, e_down = 0, e_busy = 0, e_done = 0, e_sat = 0, e_abort = 0, e_crst = 0;
  logic [NREQ-1:0] e_gnt = '0;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_active = 1'b0; m_ptr = 0;
      e_up = 0; e_down = 0; e_busy = 0; e_done = 0; e_sat = 0; e_abort = 0; e_crst = 0;
      e_gnt = '0;
    end else begin
      if (ld)          m_cnt = int'(ld_val);
      else if (e_crst) m_cnt = 0;
      else if (e_up)   m_cnt = m_cnt + 1;
      else if (e_down) m_cnt = m_cnt - 1;
      cyc++;
      m_busy_c = m_active && (cyc > m_k) && (cyc < m_done_c);
      e_gnt = '0; e_done = 0; e_sat = 0; e_abort = 0; e_crst = 0;
      if (clr) begin
        e_crst = 1;
        if (m_busy_c) begin e_done = 1; e_abort = 1; end
        m_active = 1'b0;
      end else if (m_active && (cyc + 1 == m_done_c)) begin
        e_done = 1; e_sat = m_sat;
      end else if (!m_busy_c && (req != '0)) begin
        m_idx = -1;
        for (int j = 0; j < NREQ; j++)
          if (m_idx < 0 && req[(m_ptr + j) % NREQ]) m_idx = (m_ptr + j) % NREQ;
        m_active = 1'b1;
        m_k      = cyc;
        m_dir    = dir[m_idx];
        m_len    = int'(len[m_idx*LENW +: LENW]);
        m_head   = m_dir ? (MAXV - m_cnt) : m_cnt;
        m_n      = (m_len < m_head) ? m_len : m_head;
        m_sat    = (m_len > m_head);
        m_done_c = cyc + m_n + 1 + ((m_sat || m_len == 0) ? 1 : 0);
        m_ptr    = (m_idx + 1) % NREQ;
        e_gnt[m_idx] = 1'b1;
      end
      e_busy = m_active && (cyc + 1 > m_k) && (cyc + 1 < m_done_c);
      e_up   = m_active && (cyc + 1 > m_k) && (cyc + 1 <= m_k + m_n) && m_dir;
      e_down = m_active && (cyc + 1 > m_k) && (cyc + 1 <= m_k + m_n) && !m_dir;
    end
  end

  always @(negedge clk) begin
    if (reset_n && chk_en) begin
      chk("gnt",       32'(gnt),       32'(e_gnt));
      chk("busy",      32'(busy),      32'(e_busy));
      chk("up",        32'(up),        32'(e_up));
      chk("down",      32'(down),      32'(e_down));
      chk("done",      32'(done),      32'(e_done));
      chk("sat",       32'(sat),       32'(e_sat));
      chk("aborted",   32'(aborted),   32'(e_abort));
      chk("ctr_reset", 32'(ctr_reset), 32'(e_crst));
      chk("cnt",       32'(cnt),       32'(m_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NREQ; i++) if (gnt[i]) req[i] = 1'b0;
    clr = 1'b0;
    ld  = 1'b0;
  endtask

  task automatic load(input logic [WIDTH-1:0] v);
    ld = 1'b1; ld_val = v;
    step();
  endtask

  task automatic wait_done(input string tag, output int ncyc, output int nstep);
    ncyc = 0; nstep = 0;
    do begin
      step(); ncyc++;
      nstep += int'(up) + int'(down);
    end while (!done && ncyc < 64);
    if (!done) chk({tag, "_timeout"}, 32'(done), 32'd1);
  endtask

  task automatic wait_gnt(input int idx, output int ncyc);
    ncyc = 0;
    do begin
      step(); ncyc++;
    end while (!gnt[idx] && ncyc < 32);
    chk("wait_gnt", 32'(gnt[idx]), 32'd1);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (busy && n < 40) begin step(); n++; end
    chk("settle_idle", 32'(busy), 32'd0);
    step();
  endtask

  initial begin
    int ncyc, nstep;
    int order[$];
    int rr_exp[5];
    bit rearm;
    rr_exp = '{0, 1, 2, 3, 0};
    reset_n = 1'b0; req = '0; dir = '0; len = '0; clr = 1'b0; ld = 1'b0; ld_val = '0;
    step(); step();
    chk("reset_outputs", 32'({ctr_reset, up, down, gnt, busy, done, sat, aborted}), 32'd0);
    reset_n = 1'b1;
    load(8'd5);
    chk_en = 1'b1;

    // Single up burst of 3 from 5
    req[0] = 1'b1; dir[0] = 1'b1; len[0*LENW +: LENW] = 4'd3;
    wait_done("burst", ncyc, nstep);
    chk("burst_latency", 32'(ncyc), 32'd4);
    chk("burst_steps",   32'(nstep), 32'd3);
    chk("burst_cnt",     32'(cnt), 32'd8);
    chk("burst_sat",     32'(sat), 32'd0);
    settle();

    // Saturation at the top
    load(8'hFE);
    req[1] = 1'b1; dir[1] = 1'b1; len[1*LENW +: LENW] = 4'd5;
    wait_done("satur", ncyc, nstep);
    chk("satur_latency", 32'(ncyc), 32'd3);
    chk("satur_steps",   32'(nstep), 32'd1);
    chk("satur_cnt",     32'(cnt), 32'hFF);
    chk("satur_sat",     32'(sat), 32'd1);
    step();
    chk("satur_nowrap",  32'(cnt), 32'hFF);
    settle();

    // Round robin from a fresh pointer
    req = '0; reset_n = 1'b0; step(); step(); reset_n = 1'b1;
    load(8'd100);
    req = '1; dir = '1; len = {NREQ{4'd1}};
    rearm = 1'b0; ncyc = 0;
    while (order.size() < 5 && ncyc < 60) begin
      step(); ncyc++;
      for (int i = 0; i < NREQ; i++) if (gnt[i]) order.push_back(i);
      if (gnt[0] && !rearm) begin req[0] = 1'b1; rearm = 1'b1; end
    end
    chk("rr_count", 32'(order.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      chk("rr_order", (i < order.size()) ? 32'(order[i]) : 32'hFFFF, 32'(rr_exp[i]));
    settle();

    // Abort of a 4-step down burst after its first step
    load(8'd10);
    req[2] = 1'b1; dir[2] = 1'b0; len[2*LENW +: LENW] = 4'd4;
    wait_gnt(2, ncyc);
    clr = 1'b1;
    step();
    chk("abort_flags", 32'({done, aborted, ctr_reset, down}), 32'b1110);
    chk("abort_cnt",   32'(cnt), 32'd9);
    step();
    chk("abort_cleared", 32'(cnt), 32'd0);
    chk("abort_quiet",   32'({done, busy, down}), 32'd0);
    settle();

    // Zero-length burst
    load(8'd40);
    req[3] = 1'b1; dir[3] = 1'b1; len[3*LENW +: LENW] = 4'd0;
    wait_gnt(3, ncyc);
    wait_done("len0", ncyc, nstep);
    chk("len0_latency", 32'(ncyc), 32'd1);
    chk("len0_cnt",     32'(cnt), 32'd40);
    settle();

    // Asynchronous reset mid-burst
    load(8'd20);
    req[1] = 1'b1; dir[1] = 1'b1; len[1*LENW +: LENW] = 4'd8;
    step(); step(); step();
    #2;
    reset_n = 1'b0; req = '0;
    #1;
    chk("async_reset_outputs", 32'({ctr_reset, up, down, gnt, busy, done, sat, aborted}), 32'd0);
    chk("async_reset_cnt", 32'(cnt), 32'd22);
    step(); step();
    reset_n = 1'b1;
    step(); step();
    chk("post_reset_cnt", 32'(cnt), 32'd22);

    // Random traffic
    for (int c = 0; c < 4000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && $urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
          dir[i] = 1'($urandom_range(0, 1));
          len[i*LENW +: LENW] = LENW'($urandom_range(0, 15));
        end
      end
      if ($urandom_range(0, 39) == 0) clr = 1'b1;
      else if (!busy && $urandom_range(0, 29) == 0) begin
        ld = 1'b1;
        case ($urandom_range(0, 4))
          0:       ld_val = 8'h00;
          1:       ld_val = 8'h01;
          2:       ld_val = 8'hFE;
          3:       ld_val = 8'hF5;
          default: ld_val = WIDTH'($urandom_range(0, MAXV));
        endcase
      end
    end
    req = '0;
    settle();
    step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
